lc4_limb_alu: RTL and testbench

Parametrised multi-limb ALU for wide ECC field arithmetic. It processes operands of `LIMBS × WORD_SIZE` bits as a stream of `WORD_SIZE`-bit limbs, least-significant limb first, one limb per accepted beat. Carry, borrow and shift bits are carried in a register from one limb to the next. The block sits between the register-file read stage and writeback, with valid/ready handshakes on both sides, and replaces the single-word ALU datapath for multi-word operations.

---
 rtl/lc4_limb_alu.sv | 130 +++++++++++++
 tb/tb_lc4_limb_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lc4_limb_alu.sv
// LSB-first multi-limb ALU: one limb per accepted beat, carry/borrow/shift bit chained between limbs.
// Optional zero-flag accumulator is built when LC4_LIMB_ALU_ZFLAG_EN is defined.
module lc4_limb_alu #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned LIMBS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_last,
  output logic                 o_carry,
  output logic                 o_zero
);

  localparam int unsigned CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int unsigned SW = WORD_SIZE + 1;
  localparam logic [CW-1:0] LAST_LIMB = CW'(LIMBS - 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NEG  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_PASS = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [CW-1:0]        cnt_q;
  op_e                  op_q;
  logic                 c_q;
  op_e                  op_sel;
  logic                 first;
  logic                 last;
  logic                 accept;
  logic                 c_in;
  logic                 c_nxt;
  logic [WORD_SIZE-1:0] r;
  logic [SW-1:0]        sum;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign first   = (cnt_q == '0);
  assign last    = (cnt_q == LAST_LIMB);

  // Limb 0 takes the op straight from the port and seeds the chain; later limbs use the latched state.
  always_comb begin
    op_sel = first ? op_e'(i_op) : op_q;
    c_in   = c_q;
    if (first) c_in = (op_sel == OP_SUB) || (op_sel == OP_NEG);
    sum    = '0;
    r      = i_a;
    c_nxt  = 1'b0;
    case (op_sel)
      OP_ADD: begin
        sum   = {1'b0, i_a} + {1'b0, i_b} + SW'(c_in);
        r     = sum[WORD_SIZE-1:0];
        c_nxt = sum[WORD_SIZE];
      end
      OP_SUB: begin
        sum   = {1'b0, i_a} + {1'b0, ~i_b} + SW'(c_in);
        r     = sum[WORD_SIZE-1:0];
        c_nxt = sum[WORD_SIZE];
      end
      OP_NEG: begin
        sum   = {1'b0, ~i_a} + SW'(c_in);
        r     = sum[WORD_SIZE-1:0];
        c_nxt = sum[WORD_SIZE];
      end
      OP_AND:  r = i_a & i_b;
      OP_XOR:  r = i_a ^ i_b;
      OP_SHL1: begin
        r     = {i_a[WORD_SIZE-2:0], c_in};
        c_nxt = i_a[WORD_SIZE-1];
      end
      default: r = i_a;
    endcase
  end

  // Chain state and output stage; everything freezes while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_carry <= 1'b0;
    end else if (accept) begin
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      c_q     <= c_nxt;
      if (first) op_q <= op_e'(i_op);
      o_valid <= 1'b1;
      o_data  <= r;
      o_last  <= last;
      o_carry <= c_nxt;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef LC4_LIMB_ALU_ZFLAG_EN
  logic zacc_q;
  logic zacc_d;

  assign zacc_d = first ? (r == '0) : (zacc_q && (r == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      zacc_q <= 1'b1;
      o_zero <= 1'b0;
    end else if (accept) begin
      zacc_q <= zacc_d;
      o_zero <= zacc_d;
    end
  end
`else
  assign o_zero = 1'b0;
`endif

endmodule

// File: tb/tb_lc4_limb_alu.sv
// Bench for lc4_limb_alu: 4-limb x 16-bit instance driven from a whole-operand model, plus a 1-limb instance.
module tb_lc4_limb_alu;

  localparam int unsigned W  = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned TW = W * L;
`ifdef LC4_LIMB_ALU_ZFLAG_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  typedef struct packed { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; } in_t;
  typedef struct packed { logic [W-1:0] d; logic last; logic cy; logic z; } out_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, o_ready, i_ready, o_valid, o_last, o_carry, o_zero;
  logic [2:0]   i_op;
  logic [W-1:0] i_a, i_b, o_data;
  logic         i1_valid, o1_ready, i1_ready, o1_valid, o1_last, o1_carry, o1_zero;
  logic [2:0]   i1_op;
  logic [W-1:0] i1_a, i1_b, o1_data;

  in_t  inq[$];
  out_t outq[$];
  bit   exp_valid;
  out_t exp_beat;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  lc4_limb_alu #(.WORD_SIZE(W), .LIMBS(L)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_carry(o_carry), .o_zero(o_zero)
  );

  lc4_limb_alu #(.WORD_SIZE(W), .LIMBS(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i1_valid), .o_ready(o1_ready), .i_op(i1_op),
    .i_a(i1_a), .i_b(i1_b), .o_valid(o1_valid), .i_ready(i1_ready), .o_data(o1_data),
    .o_last(o1_last), .o_carry(o1_carry), .o_zero(o1_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Whole-operand reference: compute the wide result with plain arithmetic, then slice into limbs.
  task automatic push_op(input logic [2:0] op, input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW:0]   s;
    logic [TW-1:0] res;
    logic          cy;
    s = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[TW-1:0]; cy = s[TW]; end
      3'd1: begin res = a - b; cy = (a >= b); end
      3'd2: begin res = '0 - a; cy = (a == '0); end
      3'd3: begin res = a & b; cy = 1'b0; end
      3'd4: begin res = a ^ b; cy = 1'b0; end
      3'd5: begin res = a << 1; cy = a[TW-1]; end
      default: begin res = a; cy = 1'b0; end
    endcase
    for (int i = 0; i < int'(L); i++) begin
      inq.push_back('{op: op, a: a[i*W +: W], b: b[i*W +: W]});
      outq.push_back('{d: res[i*W +: W], last: (i == int'(L) - 1), cy: cy, z: ZEN && (res == '0)});
    end
  endtask

  // One clock of the 4-limb instance, entered and left at a falling edge.
  task automatic cyc(input bit want_valid, input bit rdy);
    bit acc;
    i_ready = rdy;
    if (want_valid && inq.size() > 0) begin
      i_valid = 1'b1; i_op = inq[0].op; i_a = inq[0].a; i_b = inq[0].b;
    end else begin
      i_valid = 1'b0; i_op = 3'($urandom); i_a = W'($urandom); i_b = W'($urandom);
    end
    #1;
    chk("o_ready", 64'(o_ready), 64'(!exp_valid || rdy));
    acc = i_valid && (!exp_valid || rdy);
    @(posedge clk);
    #1;
    if (acc && outq.size() > 0) begin
      void'(inq.pop_front());
      exp_beat  = outq.pop_front();
      exp_valid = 1'b1;
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    chk("o_valid", 64'(o_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("o_data", 64'(o_data), 64'(exp_beat.d));
      chk("o_last", 64'(o_last), 64'(exp_beat.last));
      if (exp_beat.last) begin
        chk("o_carry", 64'(o_carry), 64'(exp_beat.cy));
        chk("o_zero", 64'(o_zero), 64'(exp_beat.z));
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int gap_pct, input int stall_pct);
    int budget;
    budget = 3000;
    while ((inq.size() > 0 || outq.size() > 0 || exp_valid) && budget > 0) begin
      cyc($urandom_range(99) >= 32'(gap_pct), $urandom_range(99) >= 32'(stall_pct));
      budget--;
    end
    chk("drain_budget", 64'(inq.size() + outq.size()), 64'd0);
    i_valid = 1'b0;
  endtask

  // Reset with a valid beat presented in the same cycle: reset must win.
  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b1; i_op = 3'd0; i_a = 16'hFFFF; i_b = 16'h0001; i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data", 64'(o_data), 64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_o_carry", 64'(o_carry), 64'd0);
    chk("rst_o_zero", 64'(o_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    inq.delete(); outq.delete(); exp_valid = 1'b0;
    #1;
    chk("rst_o_ready", 64'(o_ready), 64'd1);
  endtask

  // One back-to-back beat on the single-limb instance.
  task automatic cyc1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_d, input logic exp_c);
    i1_valid = 1'b1; i1_op = op; i1_a = a; i1_b = b; i1_ready = 1'b1;
    #1;
    chk("l1_o_ready", 64'(o1_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("l1_o_valid", 64'(o1_valid), 64'd1);
    chk("l1_o_data", 64'(o1_data), 64'(exp_d));
    chk("l1_o_last", 64'(o1_last), 64'd1);
    chk("l1_o_carry", 64'(o1_carry), 64'(exp_c));
    chk("l1_o_zero", 64'(o1_zero), 64'(ZEN && (exp_d == '0)));
    @(negedge clk);
  endtask

  initial begin
    logic [TW-1:0] ra, rb;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_op = '0; i_a = '0; i_b = '0;
    i1_valid = 1'b0; i1_ready = 1'b1; i1_op = '0; i1_a = '0; i1_b = '0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Directed operations from the plan.
    push_op(3'd0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
    run(0, 0);
    push_op(3'd1, 64'h0, 64'h1);
    push_op(3'd2, 64'h0, 64'hDEAD_BEEF_0123_4567);
    push_op(3'd5, 64'h8000_8000_8000_8000, 64'h0);
    run(0, 0);

    // Backpressure: back-to-back ADDs with a three-cycle downstream stall.
    push_op(3'd0, {$urandom, $urandom}, {$urandom, $urandom});
    push_op(3'd0, {$urandom, $urandom}, {$urandom, $urandom});
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    run(0, 0);

    // Abort a SUB after two limbs, then XOR equal operands.
    push_op(3'd1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0009);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    do_reset();
    push_op(3'd4, 64'h1234_1234_1234_1234, 64'h1234_1234_1234_1234);
    run(0, 0);

    // Random operations with random gaps and stalls.
    for (int n = 0; n < 30; n++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(3) == 0) ? ra : {$urandom, $urandom};
      push_op(3'($urandom_range(7)), ra, rb);
    end
    run(30, 30);

    // Single-limb instance: every beat is a complete operation.
    cyc1(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    cyc1(3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    cyc1(3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    cyc1(3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    cyc1(3'd2, 16'h0000, 16'h1111, 16'h0000, 1'b1);
    cyc1(3'd5, 16'h8001, 16'h0000, 16'h0002, 1'b1);
    i1_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("l1_drain", 64'(o1_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
